// File: rtl/vx_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vx_writeback_arbiter
// Brief    : Round-robin merge of execute-unit commit requests into one
//            registered writeback slot feeding the GPR write port.
//            Optional perf counters enabled by defining WB_ARB_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module vx_writeback_arbiter #(
    parameter int NUM_SRCS    = 4,
    parameter int NUM_THREADS = 4,
    parameter int NW_BITS     = 2,
    parameter int NR_BITS     = 5,
    parameter int DATAW       = 32
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_SRCS-1:0]                in_valid,
    input  logic [NUM_SRCS*NW_BITS-1:0]        in_wid,
    input  logic [NUM_SRCS*NR_BITS-1:0]        in_rd,
    input  logic [NUM_SRCS*NUM_THREADS-1:0]    in_tmask,
    input  logic [NUM_SRCS*NUM_THREADS*DATAW-1:0] in_data,
    output logic [NUM_SRCS-1:0]                in_ready,
    output logic                               out_valid,
    output logic [NW_BITS-1:0]                 out_wid,
    output logic [NR_BITS-1:0]                 out_rd,
    output logic [NUM_THREADS-1:0]             out_tmask,
    output logic [NUM_THREADS*DATAW-1:0]       out_data,
    input  logic                               out_ready,
    output logic [31:0]                        perf_stalls,
    output logic [31:0]                        perf_writes
);

    localparam int c_PTR_W  = (NUM_SRCS > 1) ? $clog2(NUM_SRCS) : 1;
    localparam int c_DATA_W = NUM_THREADS * DATAW;
    localparam logic [c_PTR_W-1:0] c_LAST_SRC = c_PTR_W'(NUM_SRCS - 1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);

    logic [c_PTR_W-1:0]     r_ptr;
    logic                   r_out_valid;
    logic [NW_BITS-1:0]     r_out_wid;
    logic [NR_BITS-1:0]     r_out_rd;
    logic [NUM_THREADS-1:0] r_out_tmask;
    logic [c_DATA_W-1:0]    r_out_data;

    logic                   w_load_en;
    logic                   w_any_valid;
    logic                   w_grant_hit;
    logic [c_PTR_W-1:0]     w_grant_idx;
    logic [c_PTR_W-1:0]     w_scan;
    logic [c_PTR_W-1:0]     w_ptr_next;
    logic [NW_BITS-1:0]     w_sel_wid;
    logic [NR_BITS-1:0]     w_sel_rd;
    logic [NUM_THREADS-1:0] w_sel_tmask;
    logic [c_DATA_W-1:0]    w_sel_data;

    assign w_load_en   = !r_out_valid || out_ready;
    assign w_any_valid = |in_valid;
    assign w_ptr_next  = (w_grant_idx == c_LAST_SRC) ? '0 : (w_grant_idx + c_PTR_ONE);

    // Cyclic scan starting at the pointer; first valid source wins.
    always_comb begin
        w_grant_hit = 1'b0;
        w_grant_idx = '0;
        w_scan      = r_ptr;
        for (int k = 0; k < NUM_SRCS; k++) begin
            for (int j = 0; j < NUM_SRCS; j++) begin
                if (!w_grant_hit && (w_scan == c_PTR_W'(j)) && in_valid[j]) begin
                    w_grant_hit = 1'b1;
                    w_grant_idx = c_PTR_W'(j);
                end
            end
            w_scan = (w_scan == c_LAST_SRC) ? '0 : (w_scan + c_PTR_ONE);
        end
    end

    always_comb begin
        w_sel_wid   = '0;
        w_sel_rd    = '0;
        w_sel_tmask = '0;
        w_sel_data  = '0;
        for (int j = 0; j < NUM_SRCS; j++) begin
            if (w_grant_idx == c_PTR_W'(j)) begin
                w_sel_wid   = in_wid[j*NW_BITS +: NW_BITS];
                w_sel_rd    = in_rd[j*NR_BITS +: NR_BITS];
                w_sel_tmask = in_tmask[j*NUM_THREADS +: NUM_THREADS];
                w_sel_data  = in_data[j*c_DATA_W +: c_DATA_W];
            end
        end
    end

    // Ready depends only on valids, pointer and slot state, never on payload.
    always_comb begin
        in_ready = '0;
        if (!reset && w_load_en && w_grant_hit) begin
            for (int j = 0; j < NUM_SRCS; j++) begin
                in_ready[j] = (w_grant_idx == c_PTR_W'(j));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr       <= '0;
            r_out_valid <= 1'b0;
            r_out_wid   <= '0;
            r_out_rd    <= '0;
            r_out_tmask <= '0;
            r_out_data  <= '0;
        end else if (w_load_en) begin
            if (w_any_valid) begin
                r_out_valid <= 1'b1;
                r_out_wid   <= w_sel_wid;
                r_out_rd    <= w_sel_rd;
                r_out_tmask <= w_sel_tmask;
                r_out_data  <= w_sel_data;
                r_ptr       <= w_ptr_next;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_wid   = r_out_wid;
    assign out_rd    = r_out_rd;
    assign out_tmask = r_out_tmask;
    assign out_data  = r_out_data;

`ifdef WB_ARB_PERF_EN
    logic [31:0] r_perf_stalls;
    logic [31:0] r_perf_writes;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_stalls <= '0;
            r_perf_writes <= '0;
        end else begin
            if (w_any_valid && !w_load_en) begin
                r_perf_stalls <= r_perf_stalls + 32'd1;
            end
            if (r_out_valid && out_ready) begin
                r_perf_writes <= r_perf_writes + 32'd1;
            end
        end
    end

    assign perf_stalls = r_perf_stalls;
    assign perf_writes = r_perf_writes;
`else
    assign perf_stalls = '0;
    assign perf_writes = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vx_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vx_writeback_arbiter
// Brief    : Scoreboard bench for vx_writeback_arbiter (round-robin writeback).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vx_writeback_arbiter;

    localparam int N  = 4;
    localparam int T  = 4;
    localparam int NW = 2;
    localparam int NR = 5;
    localparam int DW = 32;
    localparam int LW = T * DW;
    localparam int PW = NW + NR + T + LW;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      in_valid;
    logic [N*NW-1:0]   in_wid;
    logic [N*NR-1:0]   in_rd;
    logic [N*T-1:0]    in_tmask;
    logic [N*LW-1:0]   in_data;
    logic [N-1:0]      in_ready;
    logic              out_valid;
    logic [NW-1:0]     out_wid;
    logic [NR-1:0]     out_rd;
    logic [T-1:0]      out_tmask;
    logic [LW-1:0]     out_data;
    logic              out_ready;
    logic [31:0]       perf_stalls;
    logic [31:0]       perf_writes;

    vx_writeback_arbiter #(
        .NUM_SRCS(N), .NUM_THREADS(T), .NW_BITS(NW), .NR_BITS(NR), .DATAW(DW)
    ) u_dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_wid(in_wid), .in_rd(in_rd),
        .in_tmask(in_tmask), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_wid(out_wid), .out_rd(out_rd),
        .out_tmask(out_tmask), .out_data(out_data), .out_ready(out_ready),
        .perf_stalls(perf_stalls), .perf_writes(perf_writes)
    );

    always #5 clk = ~clk;

    // Per-source stimulus state: payload held until accepted, cnt = requests left.
    logic [NW-1:0] p_wid   [N];
    logic [NR-1:0] p_rd    [N];
    logic [T-1:0]  p_tmask [N];
    logic [LW-1:0] p_data  [N];
    int            cnt       [N];
    int            acc_total [N];
    int            acc_done  [N];

    logic [PW-1:0] sb[$];
    int            glog[$];
    int            n_checks = 0;
    int            n_fail   = 0;

    int            m_ptr;
    logic          m_ov;
    logic [31:0]   m_stalls;
    logic [31:0]   m_writes;

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic new_payload(input int i);
        p_wid[i]   = NW'($urandom);
        p_rd[i]    = NR'($urandom);
        p_tmask[i] = T'($urandom);
        p_data[i]  = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            in_valid[i]             = (cnt[i] > 0);
            in_wid[i*NW +: NW]      = p_wid[i];
            in_rd[i*NR +: NR]       = p_rd[i];
            in_tmask[i*T +: T]      = p_tmask[i];
            in_data[i*LW +: LW]     = p_data[i];
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            while (acc_done[i] < acc_total[i]) begin
                acc_done[i]++;
                if (cnt[i] > 0) cnt[i]--;
                new_payload(i);
            end
        end
        drive();
    endtask

    task automatic do_reset(input bit clear_src);
        if (clear_src) for (int i = 0; i < N; i++) cnt[i] = 0;
        reset = 1'b1;
        drive();
        cycle();
        reset = 1'b0;
        drive();
    endtask

    // Reference model and scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        logic         le, any, ov_old;
        int           g;
        logic [N-1:0] er;
        logic [PW-1:0] exp_p;
        if (reset) begin
            check_eq("rst_in_ready", in_ready, '0);
            m_ov = 1'b0; m_ptr = 0; sb.delete();
            m_stalls = '0; m_writes = '0;
        end else begin
`ifdef WB_ARB_PERF_EN
            check_eq("perf_stalls_run", perf_stalls, m_stalls);
            check_eq("perf_writes_run", perf_writes, m_writes);
`else
            check_eq("perf_stalls_off", perf_stalls, '0);
            check_eq("perf_writes_off", perf_writes, '0);
`endif
            any = |in_valid;
            le  = !m_ov || out_ready;
            g   = -1;
            for (int k = 0; k < N; k++) begin
                if (g < 0 && in_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
            er = '0;
            if (le && any) er[g] = 1'b1;
            check_eq("in_ready", in_ready, er);
            check_eq("out_valid", out_valid, m_ov);
            ov_old = m_ov;
            if (m_ov && out_ready) begin
                check_eq("sb_has_entry", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    exp_p = sb.pop_front();
                    check_eq("wb_payload", {out_wid, out_rd, out_tmask, out_data}, exp_p);
                end
            end
            if (le && any) begin
                sb.push_back({p_wid[g], p_rd[g], p_tmask[g], p_data[g]});
                glog.push_back(g);
                acc_total[g]++;
                m_ptr = (g + 1) % N;
            end
            if (le) m_ov = any;
            if (any && !le) m_stalls = m_stalls + 32'd1;
            if (ov_old && out_ready) m_writes = m_writes + 32'd1;
        end
    end

    logic [PW-1:0] saved;

    initial begin
        for (int i = 0; i < N; i++) begin
            cnt[i] = 0; acc_total[i] = 0; acc_done[i] = 0;
            new_payload(i);
        end
        m_ov = 1'b0; m_ptr = 0; m_stalls = '0; m_writes = '0;
        out_ready = 1'b1;
        reset = 1'b1;
        drive();
        cycle();
        do_reset(1'b1);
        #1;
        // Reset state
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_fields", {out_wid, out_rd, out_tmask, out_data}, '0);
        check_eq("rst_perf", {perf_stalls, perf_writes}, '0);

        // T1 single request from src2
        p_wid[2] = 2'd1; p_rd[2] = 5'd7; p_tmask[2] = 4'b1010;
        p_data[2] = {32'h44, 32'h33, 32'h22, 32'h11};
        cnt[2] = 1;
        drive();
        #1;
        check_eq("t1_in_ready", in_ready, 4'b0100);
        cycle();
        check_eq("t1_out_valid", out_valid, 1);
        check_eq("t1_out_wid", out_wid, 1);
        check_eq("t1_out_rd", out_rd, 7);
        check_eq("t1_out_tmask", out_tmask, 4'b1010);
        check_eq("t1_out_data", out_data, {32'h44, 32'h33, 32'h22, 32'h11});
        cycle();
        check_eq("t1_idle", out_valid, 0);

        // rd=0 / tmask=0 pass through
        p_rd[0] = '0; p_tmask[0] = '0;
        cnt[0] = 1;
        drive();
        cycle();
        check_eq("pass_rd0", {out_valid, out_rd, out_tmask}, {1'b1, 5'd0, 4'd0});
        cycle();

        // T2 round-robin, all sources continuously valid
        do_reset(1'b1);
        for (int i = 0; i < N; i++) cnt[i] = 1000;
        drive();
        glog.delete();
        for (int c = 0; c < 8; c++) cycle();
        check_eq("t2_ov_steady", out_valid, 1);
        check_eq("t2_grant_count", glog.size(), 8);
        for (int k = 0; k < 8; k++) check_eq("t2_grant_order", glog[k], k % N);
        for (int i = 0; i < N; i++) cnt[i] = 0;
        drive();
        cycle(); cycle();

        // T3 backpressure
        do_reset(1'b1);
        out_ready = 1'b0;
        cnt[0] = 1; cnt[1] = 1;
        drive();
        glog.delete();
        cycle();
        saved = {out_wid, out_rd, out_tmask, out_data};
        for (int c = 0; c < 5; c++) begin
            #1;
            check_eq("t3_in_ready_stall", in_ready, '0);
            check_eq("t3_out_stable", {out_valid, out_wid, out_rd, out_tmask, out_data}, {1'b1, saved});
            saved = {p_wid[1], p_rd[1], p_tmask[1], p_data[1]};
            cycle();
            saved = (c == 4) ? saved : {out_wid, out_rd, out_tmask, out_data};
        end
        out_ready = 1'b1;
        drive();
        cycle();
        check_eq("t3_src1_next", {out_valid, out_wid, out_rd, out_tmask, out_data}, {1'b1, saved});
        cycle();
        check_eq("t3_drained", out_valid, 0);
        check_eq("t3_order", {glog.size(), glog[0], glog[1]}, {32'd2, 32'd0, 32'd1});

        // T4 wrap / sparse requests
        do_reset(1'b1);
        cnt[0] = 1; cnt[1] = 1; cnt[2] = 1;
        drive();
        cycle(); cycle(); cycle();
        glog.delete();
        cnt[1] = 1;
        drive();
        cycle();
        cnt[3] = 1;
        drive();
        cycle();
        for (int i = 0; i < N; i++) cnt[i] = 1;
        drive();
        cycle();
        check_eq("t4_order", {glog[0], glog[1], glog[2]}, {32'd1, 32'd3, 32'd0});
        for (int c = 0; c < 5; c++) cycle();

        // T5 reset while a transfer is stalled
        do_reset(1'b1);
        cnt[1] = 1;
        drive();
        cycle();
        out_ready = 1'b0;
        cnt[0] = 1; cnt[2] = 1;
        drive();
        cycle();
        out_ready = 1'b1;
        reset = 1'b1;
        drive();
        #1;
        check_eq("t5_ready_in_reset", in_ready, '0);
        cycle();
        reset = 1'b0;
        drive();
        check_eq("t5_out_cleared", {out_valid, out_wid, out_rd, out_tmask, out_data}, '0);
        glog.delete();
        cycle(); cycle();
        check_eq("t5_first_grant", {glog[0], glog[1]}, {32'd0, 32'd2});
        cycle();

        // T6 perf counters: 3 stall cycles, then 4 writes
        do_reset(1'b1);
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) cnt[i] = 1;
        drive();
        for (int c = 0; c < 4; c++) cycle();
        out_ready = 1'b1;
        drive();
        for (int c = 0; c < 6; c++) cycle();
`ifdef WB_ARB_PERF_EN
        check_eq("t6_stalls", perf_stalls, 3);
        check_eq("t6_writes", perf_writes, 4);
`else
        check_eq("t6_stalls_off", perf_stalls, 0);
        check_eq("t6_writes_off", perf_writes, 0);
`endif

        // Random traffic with random backpressure
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++) begin
                if (cnt[i] == 0 && $urandom_range(3) == 0) cnt[i] = $urandom_range(4, 1);
            end
            out_ready = ($urandom_range(3) != 0);
            drive();
            cycle();
        end
        for (int i = 0; i < N; i++) cnt[i] = 0;
        out_ready = 1'b1;
        drive();
        for (int c = 0; c < 4; c++) cycle();
        check_eq("final_sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
